fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch sequencer for the 9-bit-instruction core.
- Drives ProgCtr into the instruction ROM and receives the fetched Instruction back.
- Consumes the Jump/BranchEn pair from the control decoder: a taken jump loads an absolute target from a 32-entry jump LUT, otherwise it sequences PC+1.
- Owns the start/halt handshake with the testbench or top level.

Parameters:
- PC_W, 10, width of program counter / instruction ROM address.
- LUT_AW, 5, jump LUT index width; index = Instruction[LUT_AW-1:0].
- START_ADDR, 0, PC value loaded on Start.
- HALT_INSTR, 9'h1FF, instruction encoding that halts fetch.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin/restart program; sampled in IDLE or HALT only.
- Stall  input  1  hold PC and state this cycle.
- Instruction  input  9  current instruction from ROM at ProgCtr.
- Jump  input  1  jump-class instruction, from control decoder.
- BranchEn  input  1  jump condition true, from control decoder; meaningful only when Jump=1.
- ProgCtr  output  PC_W  current fetch address (registered).
- InstrValid  output  1  Instruction is live and being executed this cycle.
- Done  output  1  program halted (registered).
- CycleCount  output  16  RUN-cycle count (optional feature).

Behaviour:
- States: IDLE, RUN, HALT; 2-bit encoding, registered.
- Reset (Reset_n=0, asynchronous): state=IDLE, ProgCtr=0, Done=0, CycleCount=0. InstrValid=0 follows from state.
- InstrValid: combinational, = (state==RUN) && !Stall.
- IDLE, Start=1: next state RUN, ProgCtr<=START_ADDR, Done<=0. Start=0: hold.
- RUN, Stall=1: ProgCtr, state and Done hold. Stall overrides halt and jump.
- RUN, Stall=0, priority order:
  - Instruction==HALT_INSTR: state<=HALT, Done<=1 next edge, ProgCtr holds at the halt address.
  - Jump && BranchEn: ProgCtr<=jump_lut[Instruction[LUT_AW-1:0]]; taken, no bubble; the target is fetched on the next cycle.
  - Otherwise, including Jump && !BranchEn: ProgCtr<=ProgCtr+1, modulo 2^PC_W. Wrap from all-ones to 0 is silent.
- BranchEn with Jump=0 is ignored; X on BranchEn while Jump=0 must not affect PC.
- Start in RUN is ignored.
- HALT: Done=1, ProgCtr frozen, InstrValid=0.
- HALT, Start=1: state<=RUN, ProgCtr<=START_ADDR, Done<=0 on the same edge.
- Reset_n asserted mid-RUN or mid-stall: immediate return to reset values; no pending jump survives.
- Jump LUT: combinational ROM, 2^LUT_AW entries of PC_W bits. Contents come from a package constant; unlisted entries are 0.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- Defined:
  - CycleCount increments every clock edge while state==RUN, stalled or not.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on the edge that accepts Start; holds in HALT and IDLE.
- Undefined: CycleCount tied to 16'h0000 and no counter register is built.

Decomposition:
- Package fetch_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, HALT=2'd2);
  - JUMP_OPC=4'b1100;
  - default HALT_INSTR;
  - the jump LUT content constant array.
- One sub-module, jump_lut: index in, PC_W-bit target out, purely combinational, instanced once.
- PC register, state machine and counter stay in fetch_unit.

Test Plan:
- Reset/start: Reset_n low mid-sequence gives ProgCtr=0, Done=0, InstrValid=0. Release, pulse Start: ProgCtr=0, InstrValid=1, then 1, 2, 3 on successive edges.
- Taken jump: LUT[3]=10'd100, ProgCtr=5, Instruction=9'b1100_00011, Jump=1, BranchEn=1. Next ProgCtr=100. With BranchEn=0, next ProgCtr=6.
- Stall and priority: Stall=1 for 3 cycles with Jump=1, BranchEn=1 pending. ProgCtr is unchanged and InstrValid=0. The jump is taken on the first unstalled edge.
- Halt/restart: Instruction=9'h1FF at ProgCtr=7 gives Done=1 next edge, ProgCtr stays 7 for 10 cycles. Start pulse gives ProgCtr=0, Done=0 on that edge.
- Wrap: ProgCtr=10'h3FF with a non-jump instruction gives next ProgCtr=0, state stays RUN.
- FETCH_CYCLE_COUNT_EN: 20 RUN cycles including 4 stalled gives CycleCount=20; it holds through HALT and clears on Start. Undefined: CycleCount is always 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM state encoding,
// jump opcode, default halt encoding and jump LUT contents.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [3:0] JUMP_OPC       = 4'b1100;
   localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

   localparam int unsigned LUT_DEPTH = 32;

   // Absolute jump targets, index 0 first; entries are wide enough for any
   // sensible PC width and are truncated at the point of use.
   localparam logic [15:0] JUMP_LUT [LUT_DEPTH] = '{
      16'd0,   16'd20,  16'd5,   16'd100, 16'd0,   16'h03FF, 16'd0,  16'd7,
      16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,    16'd0,  16'd0,
      16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,    16'd0,  16'd0,
      16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,    16'd0,  16'd0
   };

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// jump_lut: combinational ROM mapping a jump index to an absolute PC target.
module jump_lut
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 5
) (
   input  logic [LUT_AW-1:0] idx,
   output logic [PC_W-1:0]   target
);

   // Table lookup, resized to the program counter width.
   always_comb begin
      target = PC_W'(JUMP_LUT[idx]);
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and IDLE/RUN/HALT fetch sequencer.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W       = 10,
   parameter int unsigned     LUT_AW     = 5,
   parameter logic [PC_W-1:0] START_ADDR = '0,
   parameter logic [8:0]      HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            Stall,
   input  logic [8:0]      Instruction,
   input  logic            Jump,
   input  logic            BranchEn,
   output logic [PC_W-1:0] ProgCtr,
   output logic            InstrValid,
   output logic            Done,
   output logic [15:0]     CycleCount
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            done_q, done_d;
   logic [PC_W-1:0] jump_target;

   jump_lut #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW)
   ) u_jump_lut (
      .idx    (Instruction[LUT_AW-1:0]),
      .target (jump_target)
   );

   // Next state, next PC and Done; stall beats halt, halt beats jump.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            if (!Stall) begin
               if (Instruction == HALT_INSTR) begin
                  state_d = HALT;
                  done_d  = 1'b1;
               end else if (Jump && BranchEn) begin
                  pc_d = jump_target;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         HALT: begin
            done_d = 1'b1;
            if (Start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   // State, PC and Done registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   assign ProgCtr    = pc_q;
   assign Done       = done_q;
   assign InstrValid = (state_q == RUN) && !Stall;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0] cyc_q, cyc_d;

   // Saturating RUN-cycle counter, cleared when Start is accepted.
   always_comb begin
      cyc_d = cyc_q;
      if (Start && (state_q == IDLE || state_q == HALT)) begin
         cyc_d = '0;
      end else if (state_q == RUN && cyc_q != '1) begin
         cyc_d = cyc_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign CycleCount = cyc_q;
`else
   assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start, Stall, Jump, BranchEn;
   logic [8:0]  Instruction;
   logic [9:0]  ProgCtr;
   logic        InstrValid, Done;
   logic [15:0] CycleCount;

   typedef struct {
      string       tag;
      logic [9:0]  pc;
      logic        valid;
      logic        done;
      logic [15:0] cc;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   localparam logic [8:0] NOP = 9'h000;
   localparam logic [8:0] HLT = 9'h1FF;

   fetch_unit #(
      .PC_W       (10),
      .LUT_AW     (5),
      .START_ADDR (10'd0),
      .HALT_INSTR (9'h1FF)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Start       (Start),
      .Stall       (Stall),
      .Instruction (Instruction),
      .Jump        (Jump),
      .BranchEn    (BranchEn),
      .ProgCtr     (ProgCtr),
      .InstrValid  (InstrValid),
      .Done        (Done),
      .CycleCount  (CycleCount)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] cc(input int n);
`ifdef FETCH_CYCLE_COUNT_EN
      return 16'(n);
`else
      return 16'(0 * n);
`endif
   endfunction

   function automatic logic [8:0] jmp(input int idx);
      logic [4:0] i5;
      i5 = 5'(idx);
      return {JUMP_OPC, i5};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [9:0] pc, input logic v,
                       input logic d, input logic [15:0] c);
      exp_t e;
      e.tag = tag; e.pc = pc; e.valid = v; e.done = d; e.cc = c;
      sb.push_back(e);
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         total_cnt++;
         $error("FAIL scoreboard: observed empty queue, expected entry");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".pc"},    16'(ProgCtr),    16'(e.pc));
      chk({e.tag, ".valid"}, 16'(InstrValid), 16'(e.valid));
      chk({e.tag, ".done"},  16'(Done),       16'(e.done));
      chk({e.tag, ".cc"},    CycleCount,      e.cc);
   endtask

   // Drive one cycle of inputs, queue the post-edge expectation, check it.
   task automatic cyc(input string tag, input logic st, input logic sl,
                      input logic [8:0] ins, input logic j, input logic b,
                      input logic [9:0] epc, input logic ev, input logic ed,
                      input logic [15:0] ecc);
      Start = st; Stall = sl; Instruction = ins; Jump = j; BranchEn = b;
      push(tag, epc, ev, ed, ecc);
      @(posedge Clk);
      #1;
      compare_head();
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0;
      Instruction = NOP; Jump = 1'b0; BranchEn = 1'b0;
      #1;
      push("reset", 10'd0, 1'b0, 1'b0, 16'd0);
      compare_head();
      repeat (2) @(posedge Clk);
      #2 Reset_n = 1'b1;

      // Start and sequential fetch
      cyc("start",   1, 0, NOP, 0, 0, 10'd0, 1, 0, cc(0));
      cyc("seq1",    0, 0, NOP, 0, 0, 10'd1, 1, 0, cc(1));
      cyc("seq2",    0, 0, NOP, 0, 0, 10'd2, 1, 0, cc(2));
      cyc("seq3",    0, 0, NOP, 0, 0, 10'd3, 1, 0, cc(3));
      cyc("seq4",    0, 0, NOP, 0, 0, 10'd4, 1, 0, cc(4));
      cyc("seq5",    0, 0, NOP, 0, 0, 10'd5, 1, 0, cc(5));
      // Jumps
      cyc("nottaken",0, 0, jmp(3), 1, 0, 10'd6,   1, 0, cc(6));
      cyc("jmp2",    0, 0, jmp(2), 1, 1, 10'd5,   1, 0, cc(7));
      cyc("taken",   0, 0, jmp(3), 1, 1, 10'd100, 1, 0, cc(8));
      cyc("brx",     0, 0, jmp(3), 0, 1'bx, 10'd101, 1, 0, cc(9));
      // Stall with pending jump
      cyc("stall1",  0, 1, jmp(3), 1, 1, 10'd101, 0, 0, cc(10));
      cyc("stall2",  0, 1, jmp(3), 1, 1, 10'd101, 0, 0, cc(11));
      cyc("stall3",  0, 1, jmp(3), 1, 1, 10'd101, 0, 0, cc(12));
      cyc("unstall", 0, 0, jmp(3), 1, 1, 10'd100, 1, 0, cc(13));
      cyc("stallhlt",0, 1, HLT,    0, 0, 10'd100, 0, 0, cc(14));
      // Wrap
      cyc("to3ff",   0, 0, jmp(5), 1, 1, 10'h3FF, 1, 0, cc(15));
      cyc("wrap",    0, 0, NOP,    0, 0, 10'd0,   1, 0, cc(16));
      cyc("wrap1",   0, 0, NOP,    0, 0, 10'd1,   1, 0, cc(17));
      cyc("wrap2",   0, 0, NOP,    0, 0, 10'd2,   1, 0, cc(18));
      // Halt at address 7
      cyc("to7",     0, 0, jmp(7), 1, 1, 10'd7,   1, 0, cc(19));
      cyc("halt",    0, 0, HLT,    0, 0, 10'd7,   0, 1, cc(20));
      for (int i = 0; i < 10; i++)
         cyc("halthold", 0, 0, jmp(3), 1, 1, 10'd7, 0, 1, cc(20));
      // Restart, then Start ignored in RUN
      cyc("restart", 1, 0, NOP, 0, 0, 10'd0, 1, 0, cc(0));
      cyc("runstart",1, 0, NOP, 0, 0, 10'd1, 1, 0, cc(1));
      // Asynchronous reset during a stall with a pending jump
      cyc("prerst",  0, 1, jmp(3), 1, 1, 10'd1, 0, 0, cc(2));
      #2 Reset_n = 1'b0;
      #1;
      push("asyncrst", 10'd0, 1'b0, 1'b0, 16'd0);
      compare_head();
      cyc("inrst",   0, 1, jmp(3), 1, 1, 10'd0, 0, 0, 16'd0);
      #2 Reset_n = 1'b1;
      cyc("postrst", 0, 0, jmp(3), 1, 1, 10'd0, 0, 0, 16'd0);
      cyc("start2",  1, 0, NOP,    0, 0, 10'd0, 1, 0, 16'd0);
      cyc("seq2_1",  0, 0, NOP,    0, 0, 10'd1, 1, 0, cc(1));

      if (sb.size() != 0) begin
         total_cnt++;
         $error("FAIL leftover: observed %0d entries, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
